// File: rtl/score_pkg.sv
// Shared definitions for the score leaderboard slice.
// Holds the default widths, the controller state encoding and the
// leaderboard entry layout used by score_leaderboard and score_topn_insert.
package score_pkg;

    localparam int DEF_SCORE_W  = 14;
    localparam int DEF_PLAYER_W = 5;
    localparam int DEF_TOP_N    = 4;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        CMP   = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic                    valid;
        logic                    guest;
        logic [DEF_PLAYER_W-1:0] id;
        logic [DEF_SCORE_W-1:0]  score;
    } lb_entry_t;

endpackage

// File: rtl/score_topn_insert.sv
// Sorted top-N leaderboard storage.
//   clr                      : synchronous wipe of all valid bits
//   srch_score               : score being placed; srch_pos/srch_found give the
//                              first slot that is empty or holds a lower score
//   ins_en/ins_pos/ins_*     : shift entries at and below ins_pos down by one
//                              (last entry falls off) and write the new entry
//   q_idx -> q_score/q_id/q_valid : combinational query read; q_id is all-zeros
//                              for guest entries
module score_topn_insert
    import score_pkg::*;
#(
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int PLAYER_W = DEF_PLAYER_W,
    parameter int TOP_N    = DEF_TOP_N,
    parameter int IDX_W    = (TOP_N > 1) ? $clog2(TOP_N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [SCORE_W-1:0]  srch_score,
    output logic [IDX_W-1:0]    srch_pos,
    output logic                srch_found,
    input  logic                ins_en,
    input  logic [IDX_W-1:0]    ins_pos,
    input  logic [SCORE_W-1:0]  ins_score,
    input  logic [PLAYER_W-1:0] ins_id,
    input  logic                ins_guest,
    input  logic [IDX_W-1:0]    q_idx,
    output logic [SCORE_W-1:0]  q_score,
    output logic [PLAYER_W-1:0] q_id,
    output logic                q_valid
);

    logic                valid_q [TOP_N];
    logic                valid_d [TOP_N];
    logic                guest_q [TOP_N];
    logic                guest_d [TOP_N];
    logic [PLAYER_W-1:0] id_q    [TOP_N];
    logic [PLAYER_W-1:0] id_d    [TOP_N];
    logic [SCORE_W-1:0]  score_q [TOP_N];
    logic [SCORE_W-1:0]  score_d [TOP_N];

    // Position search: strict '>' makes a tie land below the existing entry.
    always_comb begin
        srch_found = 1'b0;
        srch_pos   = {IDX_W{1'b0}};
        for (int i = 0; i < TOP_N; i++) begin
            if (!srch_found && (!valid_q[i] || (srch_score > score_q[i]))) begin
                srch_found = 1'b1;
                srch_pos   = IDX_W'(i);
            end else begin
                srch_found = srch_found;
            end
        end
    end

    // Next-state of the board: clear, or shift-down-and-insert.
    always_comb begin
        for (int i = 0; i < TOP_N; i++) begin
            valid_d[i] = valid_q[i];
            guest_d[i] = guest_q[i];
            id_d[i]    = id_q[i];
            score_d[i] = score_q[i];
        end
        if (clr) begin
            for (int i = 0; i < TOP_N; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (ins_en) begin
            for (int i = 1; i < TOP_N; i++) begin
                if (i > int'(ins_pos)) begin
                    valid_d[i] = valid_q[i-1];
                    guest_d[i] = guest_q[i-1];
                    id_d[i]    = id_q[i-1];
                    score_d[i] = score_q[i-1];
                end else begin
                    valid_d[i] = valid_q[i];
                end
            end
            valid_d[ins_pos] = 1'b1;
            guest_d[ins_pos] = ins_guest;
            id_d[ins_pos]    = ins_id;
            score_d[ins_pos] = ins_score;
        end else begin
            valid_d[0] = valid_q[0];
        end
    end

    // Board registers; reset empties the board.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TOP_N; i++) begin
                valid_q[i] <= 1'b0;
                guest_q[i] <= 1'b0;
                id_q[i]    <= {PLAYER_W{1'b0}};
                score_q[i] <= {SCORE_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < TOP_N; i++) begin
                valid_q[i] <= valid_d[i];
                guest_q[i] <= guest_d[i];
                id_q[i]    <= id_d[i];
                score_q[i] <= score_d[i];
            end
        end
    end

    // Query read mux; guest entries hide their player ID.
    always_comb begin
        q_valid = 1'b0;
        q_score = {SCORE_W{1'b0}};
        q_id    = {PLAYER_W{1'b0}};
        if (int'(q_idx) < TOP_N) begin
            q_valid = valid_q[q_idx];
            q_score = score_q[q_idx];
            q_id    = guest_q[q_idx] ? {PLAYER_W{1'b0}} : id_q[q_idx];
        end else begin
            q_valid = 1'b0;
        end
    end

endmodule

// File: rtl/score_leaderboard.sv
// Score leaderboard: per-player personal-best table plus sorted top-N board.
// Ports: clk/rst (async active-high), clear_req (wipe, taken in IDLE only),
//   score_valid/score_ready handshake with player_id, is_guest, score;
//   results done (1-cycle pulse), personal_best, global_best, rank (0 = not
//   placed); query port lb_idx -> lb_score, lb_id, lb_valid (combinational).
// Build option: SCORE_LB_GUEST_RANK_EN lets guest submissions enter the
//   leaderboard (stored with their ID hidden). Without it guests never place.
module score_leaderboard
    import score_pkg::*;
#(
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int PLAYER_W = DEF_PLAYER_W,
    parameter int TOP_N    = DEF_TOP_N,
    localparam int IDX_W   = (TOP_N > 1) ? $clog2(TOP_N) : 1,
    localparam int RANK_W  = $clog2(TOP_N + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_req,
    input  logic                score_valid,
    output logic                score_ready,
    input  logic [PLAYER_W-1:0] player_id,
    input  logic                is_guest,
    input  logic [SCORE_W-1:0]  score,
    output logic                done,
    output logic                personal_best,
    output logic                global_best,
    output logic [RANK_W-1:0]   rank,
    input  logic [IDX_W-1:0]    lb_idx,
    output logic [SCORE_W-1:0]  lb_score,
    output logic [PLAYER_W-1:0] lb_id,
    output logic                lb_valid
);

    localparam int NUM_PLAYERS = 2 ** PLAYER_W;

`ifdef SCORE_LB_GUEST_RANK_EN
    localparam logic GUEST_RANK = 1'b1;
`else
    localparam logic GUEST_RANK = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [PLAYER_W-1:0] cnt_q, cnt_d;
    logic [PLAYER_W-1:0] id_q, id_d;
    logic                guest_q, guest_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SCORE_W-1:0]  stored_q, stored_d;
    logic                pb_q, pb_d;
    logic                place_q, place_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic                done_q, done_d;
    logic                pbest_q, pbest_d;
    logic                gbest_q, gbest_d;
    logic [RANK_W-1:0]   rank_q, rank_d;

    logic [SCORE_W-1:0]  tbl_q [NUM_PLAYERS];
    logic                tbl_we;
    logic [PLAYER_W-1:0] tbl_waddr;
    logic [SCORE_W-1:0]  tbl_wdata;

    logic                lb_clr;
    logic                ins_en;
    logic [IDX_W-1:0]    srch_pos;
    logic                srch_found;

    assign score_ready   = (state_q == IDLE) && !clear_req;
    assign done          = done_q;
    assign personal_best = pbest_q;
    assign global_best   = gbest_q;
    assign rank          = rank_q;

    score_topn_insert #(
        .SCORE_W  (SCORE_W),
        .PLAYER_W (PLAYER_W),
        .TOP_N    (TOP_N),
        .IDX_W    (IDX_W)
    ) u_topn (
        .clk        (clk),
        .rst        (rst),
        .clr        (lb_clr),
        .srch_score (score_q),
        .srch_pos   (srch_pos),
        .srch_found (srch_found),
        .ins_en     (ins_en),
        .ins_pos    (k_q),
        .ins_score  (score_q),
        .ins_id     (id_q),
        .ins_guest  (guest_q),
        .q_idx      (lb_idx),
        .q_score    (lb_score),
        .q_id       (lb_id),
        .q_valid    (lb_valid)
    );

    // Controller next-state, table write port and result computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        guest_d   = guest_q;
        score_d   = score_q;
        stored_d  = stored_q;
        pb_d      = pb_q;
        place_d   = place_q;
        k_d       = k_q;
        done_d    = 1'b0;
        pbest_d   = pbest_q;
        gbest_d   = gbest_q;
        rank_d    = rank_q;
        tbl_we    = 1'b0;
        tbl_waddr = id_q;
        tbl_wdata = score_q;
        lb_clr    = 1'b0;
        ins_en    = 1'b0;
        case (state_q)
            INIT: begin
                tbl_we    = 1'b1;
                tbl_waddr = cnt_q;
                tbl_wdata = {SCORE_W{1'b0}};
                if (cnt_q == PLAYER_W'(NUM_PLAYERS - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + {{(PLAYER_W-1){1'b0}}, 1'b1};
                end
            end
            IDLE: begin
                if (clear_req) begin
                    lb_clr  = 1'b1;
                    cnt_d   = {PLAYER_W{1'b0}};
                    state_d = INIT;
                end else if (score_valid) begin
                    id_d    = player_id;
                    guest_d = is_guest;
                    score_d = score;
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                // Guests never touch the table; a zero compare value is harmless.
                if (guest_q) begin
                    stored_d = {SCORE_W{1'b0}};
                end else begin
                    stored_d = tbl_q[id_q];
                end
                state_d = CMP;
            end
            CMP: begin
                // Strict '>' against a non-negative stored value also rules out score 0.
                pb_d    = !guest_q && (score_q > stored_q);
                place_d = srch_found && (score_q != {SCORE_W{1'b0}}) &&
                          (!guest_q || GUEST_RANK);
                k_d     = srch_pos;
                state_d = WRITE;
            end
            WRITE: begin
                tbl_we  = pb_q;
                ins_en  = place_q;
                pbest_d = pb_q;
                if (place_q) begin
                    rank_d  = RANK_W'(k_q) + {{(RANK_W-1){1'b0}}, 1'b1};
                    gbest_d = (k_q == {IDX_W{1'b0}});
                end else begin
                    rank_d  = {RANK_W{1'b0}};
                    gbest_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                pbest_d = 1'b0;
                gbest_d = 1'b0;
                rank_d  = {RANK_W{1'b0}};
            end
        endcase
    end

    // Controller and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT;
            cnt_q    <= {PLAYER_W{1'b0}};
            id_q     <= {PLAYER_W{1'b0}};
            guest_q  <= 1'b0;
            score_q  <= {SCORE_W{1'b0}};
            stored_q <= {SCORE_W{1'b0}};
            pb_q     <= 1'b0;
            place_q  <= 1'b0;
            k_q      <= {IDX_W{1'b0}};
            done_q   <= 1'b0;
            pbest_q  <= 1'b0;
            gbest_q  <= 1'b0;
            rank_q   <= {RANK_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            guest_q  <= guest_d;
            score_q  <= score_d;
            stored_q <= stored_d;
            pb_q     <= pb_d;
            place_q  <= place_d;
            k_q      <= k_d;
            done_q   <= done_d;
            pbest_q  <= pbest_d;
            gbest_q  <= gbest_d;
            rank_q   <= rank_d;
        end
    end

    // Personal-best table; contents are defined by the INIT sweep, not reset.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_q[tbl_waddr] <= tbl_wdata;
        end
    end

endmodule

// File: tb/tb_score_leaderboard.sv
// Directed bench for score_leaderboard with a behavioural reference model.
module tb_score_leaderboard;

`ifdef SCORE_LB_GUEST_RANK_EN
    localparam bit GUEST_EN = 1'b1;
`else
    localparam bit GUEST_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_req = 1'b0;
    logic        score_valid = 1'b0;
    logic        score_ready;
    logic [4:0]  player_id = 5'd0;
    logic        is_guest = 1'b0;
    logic [13:0] score = 14'd0;
    logic        done;
    logic        personal_best;
    logic        global_best;
    logic [2:0]  rank;
    logic [1:0]  lb_idx = 2'd0;
    logic [13:0] lb_score;
    logic [4:0]  lb_id;
    logic        lb_valid;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int m_tbl [32];
    bit m_v   [4];
    bit m_g   [4];
    int m_id  [4];
    int m_sc  [4];

    score_leaderboard dut (
        .clk           (clk),
        .rst           (rst),
        .clear_req     (clear_req),
        .score_valid   (score_valid),
        .score_ready   (score_ready),
        .player_id     (player_id),
        .is_guest      (is_guest),
        .score         (score),
        .done          (done),
        .personal_best (personal_best),
        .global_best   (global_best),
        .rank          (rank),
        .lb_idx        (lb_idx),
        .lb_score      (lb_score),
        .lb_id         (lb_id),
        .lb_valid      (lb_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_tbl[i] = 0;
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 1'b0; m_g[i] = 1'b0; m_id[i] = 0; m_sc[i] = 0;
        end
    endtask

    // Board as a sorted list: find first slot that is empty or beaten, push the rest down.
    task automatic model_submit(input int pid, input bit g, input int s,
                                output bit pb, output int rk);
        int  k;
        bit  allow;
        pb    = !g && (s > m_tbl[pid]);
        allow = (s != 0) && (!g || GUEST_EN);
        k = -1;
        for (int i = 0; i < 4; i++)
            if (k < 0 && (!m_v[i] || s > m_sc[i])) k = i;
        rk = 0;
        if (allow && k >= 0) begin
            for (int j = 3; j > k; j--) begin
                m_v[j] = m_v[j-1]; m_g[j] = m_g[j-1]; m_id[j] = m_id[j-1]; m_sc[j] = m_sc[j-1];
            end
            m_v[k] = 1'b1; m_g[k] = g; m_id[k] = pid; m_sc[k] = s;
            rk = k + 1;
        end
        if (pb) m_tbl[pid] = s;
    endtask

    task automatic check_board();
        for (int i = 0; i < 4; i++) begin
            lb_idx = 2'(i);
            #1;
            check($sformatf("lb_valid[%0d]", i), lb_valid, m_v[i]);
            if (m_v[i]) begin
                check($sformatf("lb_score[%0d]", i), lb_score, m_sc[i]);
                check($sformatf("lb_id[%0d]", i), lb_id, m_g[i] ? 0 : m_id[i]);
            end
        end
    endtask

    // Called right after a negedge; counts samples with score_ready low.
    task automatic wait_init(input string tag);
        int zeros = 0;
        bit saw_done = 1'b0;
        #1;
        while (!score_ready && zeros < 200) begin
            if (done) saw_done = 1'b1;
            zeros++;
            @(negedge clk);
            #1;
        end
        check({tag, "_init_cycles"}, zeros, 32);
        check({tag, "_no_done"}, saw_done, 1'b0);
    endtask

    task automatic submit(input logic [4:0] pid, input bit g, input logic [13:0] s,
                          input bit exp_pb, input int exp_rank);
        int waitc = 0;
        int lat = 0;
        bit mpb;
        int mrank;
        @(negedge clk);
        while (!score_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!score_ready) begin
            check("ready_timeout", score_ready, 1'b1);
            return;
        end
        player_id = pid; is_guest = g; score = s; score_valid = 1'b1;
        @(posedge clk);
        #1 score_valid = 1'b0;
        model_submit(int'(pid), g, int'(s), mpb, mrank);
        check("model_pb_pin", mpb, exp_pb);
        check("model_rank_pin", mrank, exp_rank);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        check("done_latency", lat, 4);
        check("personal_best", personal_best, mpb);
        check("global_best", global_best, (mrank == 1));
        check("rank", rank, mrank);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("rank_hold", rank, mrank);
        check_board();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_done", done, 1'b0);
        check("rst_pb", personal_best, 1'b0);
        check("rst_gb", global_best, 1'b0);
        check("rst_rank", rank, 0);
        check("rst_ready", score_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_init("reset");
        check_board();

        submit(5'd3, 1'b0, 14'd100, 1'b1, 1);
        submit(5'd3, 1'b0, 14'd80,  1'b0, 2);
        submit(5'd7, 1'b0, 14'd100, 1'b1, 2);

        // clear with a simultaneous submission: clear wins
        @(negedge clk);
        clear_req = 1'b1; score_valid = 1'b1; player_id = 5'd4; score = 14'd555;
        #1;
        check("clear_ready_low", score_ready, 1'b0);
        @(negedge clk);
        clear_req = 1'b0; score_valid = 1'b0;
        model_reset();
        wait_init("clear");
        check_board();

        submit(5'd1, 1'b0, 14'd50, 1'b1, 1);
        submit(5'd2, 1'b0, 14'd40, 1'b1, 2);
        submit(5'd4, 1'b0, 14'd30, 1'b1, 3);
        submit(5'd5, 1'b0, 14'd20, 1'b1, 4);
        submit(5'd6, 1'b0, 14'd10, 1'b1, 0);
        submit(5'd8, 1'b0, 14'd45, 1'b1, 2);
        submit(5'd3, 1'b0, 14'd1,  1'b1, 0);
        submit(5'd6, 1'b0, 14'd0,  1'b0, 0);

`ifdef SCORE_LB_GUEST_RANK_EN
        submit(5'd9, 1'b1, 14'd999, 1'b0, 1);
`else
        submit(5'd9, 1'b1, 14'd999, 1'b0, 0);
`endif
        submit(5'd9, 1'b0, 14'd5, 1'b1, 0);

        // reset during CMP aborts the submission
        @(negedge clk);
        player_id = 5'd3; is_guest = 1'b0; score = 14'd500; score_valid = 1'b1;
        @(posedge clk);
        #1 score_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_init("midrst");
        check_board();
        submit(5'd3, 1'b0, 14'd7, 1'b1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/score_leaderboard.md
Name: score_leaderboard

Overview:
- Parametrised successor of the per-game score tracker.
- Holds a per-player personal-best table in internal registers and a sorted top-N leaderboard.
- Accepts one end-of-game score per valid/ready handshake and reports personal-best, global-best and leaderboard rank.
- Sits between the game controller, which submits scores, and the display logic, which reads the leaderboard through a query port.

Parameters:
SCORE_W, 14, score width in bits (unsigned)
PLAYER_W, 5, player ID width; table depth NUM_PLAYERS = 2**PLAYER_W
TOP_N, 4, number of leaderboard entries (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
clear_req  in  1  level; wipe table and leaderboard (taken only in IDLE)
score_valid  in  1  submission valid
score_ready  out  1  = (state==IDLE) && !clear_req
player_id  in  PLAYER_W  submitting player
is_guest  in  1  guest submission: no table access
score  in  SCORE_W  final game score
done  out  1  one-cycle pulse: result outputs updated
personal_best  out  1  score beat stored personal best
global_best  out  1  score placed at rank 1
rank  out  $clog2(TOP_N+1)  1..TOP_N placed; 0 = not placed
lb_idx  in  $clog2(TOP_N)  query index; 0 = highest
lb_score  out  SCORE_W  combinational read of entry lb_idx
lb_id  out  PLAYER_W  player ID of entry lb_idx
lb_valid  out  1  entry lb_idx occupied

Behaviour:
- Reset (async, rst=1): state=INIT, init counter=0, all leaderboard valid bits=0. done, personal_best, global_best=0; rank=0. Table contents are undefined until INIT completes.
- INIT: writes table[counter]=0, one entry per cycle; after entry NUM_PLAYERS-1 goes to IDLE. Occupies exactly NUM_PLAYERS cycles; score_ready=0 throughout.
- IDLE: clear_req=1 -> clears leaderboard valids, counter=0, goes to INIT; a simultaneous score_valid is not accepted. Accept on score_valid && score_ready: latch id/guest/score, go to READ.
- READ: registered read of table[id]; guests skip the read.
- CMP:
  - pb = !guest && score > stored, strictly.
  - Insertion position k = first entry that is invalid or has score > entry score. Ties rank below existing entries.
  - score==0 is never placed and never a personal best.
- WRITE: if pb, table[id]=score. If placed, entries k..TOP_N-2 shift down one, the last is dropped, and the new entry is written at k. Result regs: personal_best=pb, rank=k+1 or 0, global_best=(rank==1).
- DONE: done=1 for this cycle only, then IDLE.
- Latency: acceptance edge T -> done high in cycle T+4. Results hold until the next acceptance's WRITE.
- The leaderboard permits multiple entries for the same player.
- rst asserted mid-operation aborts the submission and restarts INIT. No done pulse is produced.
- Illegal state encoding -> IDLE with result regs cleared.

Optional Feature:
- SCORE_LB_GUEST_RANK_EN defined: guests compete for the leaderboard. Entries carry a guest flag; lb_id reads all-zeros for guest entries. personal_best is still 0 for guests.
- Undefined: guests never enter the leaderboard; a guest result is rank=0, global_best=0, personal_best=0.

Decomposition:
- score_pkg holds: SCORE_W/PLAYER_W defaults, state enum (INIT, IDLE, READ, CMP, WRITE, DONE), lb_entry_t struct {valid, guest, id, score}.
- Sub-module score_topn_insert: combinational position search plus registered shift-insert of TOP_N entries. It also provides the query read mux.

Test Plan:
- Reset then hold: score_ready=0 for 32 cycles, then 1. lb_valid=0 for idx 0..3.
- Player 3 submits 100 -> done at T+4, personal_best=1, global_best=1, rank=1; lb[0]={3,100}.
- Player 3 submits 80, then player 7 submits 100 -> first: pb=0, rank=2; second: rank=2 (tie below existing 100); board 100(3),100(7),80(3).
- Fill with 50,40,30,20, then submit 10 -> rank=0, board unchanged. Then submit 45 -> rank=2, entry 20 dropped.
- Guest submits 999 (macro undefined) -> rank=0, pb=0, table unchanged. With macro defined -> rank=1, lb_id=0.
- Assert clear_req with score_valid in IDLE -> not accepted, INIT re-runs. After it, player 3 submitting 1 gives pb=1. rst pulsed during CMP -> no done, INIT restarts.
